// File: rtl/elevator_button_conditioner_pkg.sv
// Shared elevator definitions: button bit positions and the default channel count.
package elevator_pkg;

    localparam int BTN_FL1_UP = 0;
    localparam int BTN_FL2_UP = 1;
    localparam int BTN_FL2_DN = 2;
    localparam int BTN_FL3_DN = 3;
    localparam int BTN_CAB1   = 4;
    localparam int BTN_CAB2   = 5;
    localparam int BTN_CAB3   = 6;

    localparam int N_BUTTONS_DEFAULT = 7;

endpackage

// File: rtl/elevator_button_conditioner_if.sv
// Button bundle between the raw panel inputs and the conditioned outputs.
interface elevator_button_conditioner_if
    import elevator_pkg::*;
#(
    parameter int N = N_BUTTONS_DEFAULT
);
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_mask;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_stuck;

    modport master (output btn_raw, output btn_mask,
                    input  btn_level, input btn_press, input btn_stuck);
    modport slave  (input  btn_raw, input btn_mask,
                    output btn_level, output btn_press, output btn_stuck);
endinterface

// File: rtl/elevator_button_conditioner_debounce_cell.sv
// One button channel: synchronizer, debounce counter, press pulse.
// Held-button stuck detection is built only when ELEVATOR_STUCK_DETECT_EN is defined.
module button_debounce_cell #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STUCK_CYCLES    = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic press_en,
    output logic level,
    output logic press,
    output logic stuck
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   sync;
    logic                   stuck_flag;

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], raw};
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync;
                press_d = sync & press_en & ~stuck_flag;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

`ifdef ELEVATOR_STUCK_DETECT_EN
    localparam int HELD_W = $clog2(STUCK_CYCLES + 1);
    localparam logic [HELD_W-1:0] HELD_MAX = HELD_W'(STUCK_CYCLES);

    logic [HELD_W-1:0] held_q, held_d;
    logic              stuck_q, stuck_d;

    // counter saturates so the flag stays up for as long as the level does
    always_comb begin
        held_d  = '0;
        if (level_q) begin
            held_d = (held_q == HELD_MAX) ? held_q : held_q + 1'b1;
        end
        stuck_d = level_q && (held_d == HELD_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            held_q  <= '0;
            stuck_q <= 1'b0;
        end else begin
            held_q  <= held_d;
            stuck_q <= stuck_d;
        end
    end

    assign stuck_flag = stuck_q;
`else
    assign stuck_flag = 1'b0;
`endif

    assign level = level_q;
    assign press = press_q;
    assign stuck = stuck_flag;
endmodule

// File: rtl/elevator_button_conditioner.sv
// Conditions the raw elevator call/cab buttons into debounced levels and press pulses.
// Optional stuck-button detection: define ELEVATOR_STUCK_DETECT_EN.
module elevator_button_conditioner
    import elevator_pkg::*;
#(
    parameter int N_BUTTONS       = N_BUTTONS_DEFAULT,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STUCK_CYCLES    = 1024
) (
    input  logic clk,
    input  logic rst,
    elevator_button_conditioner_if.slave bif
);
    logic [N_BUTTONS-1:0] press_en;
    logic [N_BUTTONS-1:0] level_w;
    logic [N_BUTTONS-1:0] press_w;
    logic [N_BUTTONS-1:0] stuck_w;

    // mask is sampled on the accepting edge, so a masked press is lost rather than deferred
    assign press_en = ~bif.btn_mask;

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_cell
        button_debounce_cell #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .STUCK_CYCLES    (STUCK_CYCLES)
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .raw      (bif.btn_raw[i]),
            .press_en (press_en[i]),
            .level    (level_w[i]),
            .press    (press_w[i]),
            .stuck    (stuck_w[i])
        );
    end

    assign bif.btn_level = level_w;
    assign bif.btn_press = press_w;
    assign bif.btn_stuck = stuck_w;
endmodule

// File: tb/tb_elevator_button_conditioner.sv
// Bench for elevator_button_conditioner: directed scenarios then random stimulus, two instances
// (DEBOUNCE_CYCLES 4 and 1) compared every cycle against a sample-window reference model.
module tb_elevator_button_conditioner;
    import elevator_pkg::*;

    localparam int N     = N_BUTTONS_DEFAULT;
    localparam int SYNC  = 2;
    localparam int STUCK = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    elevator_button_conditioner_if #(.N(N)) bif0 ();
    elevator_button_conditioner_if #(.N(N)) bif1 ();

    elevator_button_conditioner #(
        .N_BUTTONS(N), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(4), .STUCK_CYCLES(STUCK)
    ) u_dut0 (.clk(clk), .rst(rst), .bif(bif0));

    elevator_button_conditioner #(
        .N_BUTTONS(N), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(1), .STUCK_CYCLES(STUCK)
    ) u_dut1 (.clk(clk), .rst(rst), .bif(bif1));

    int checks = 0;
    int errors = 0;

    // rh[k] = raw value sampled k+1 edges ago (zeros while in reset)
    logic [N-1:0] rh [0:7];
    logic [N-1:0] m_lvl   [2];
    logic [N-1:0] m_press [2];
    logic [N-1:0] m_stuck [2];
    int           m_held  [2][N];

    function automatic int deb_of(input int m);
        return (m == 0) ? 4 : 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A level flips once the synchronized input has shown the opposite value for the last
    // DEBOUNCE_CYCLES edges; sync seen at an edge is the raw sample from SYNC edges earlier.
    task automatic model_edge(input logic [N-1:0] raw, input logic [N-1:0] mask, input logic r);
        if (r) begin
            for (int k = 0; k < 8; k++) rh[k] = '0;
            for (int m = 0; m < 2; m++) begin
                m_lvl[m] = '0; m_press[m] = '0; m_stuck[m] = '0;
                for (int c = 0; c < N; c++) m_held[m][c] = 0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                logic [N-1:0] newl;
                logic [N-1:0] stk_pre;
                stk_pre = m_stuck[m];
                for (int c = 0; c < N; c++) begin
                    bit flip;
                    flip = 1'b1;
                    for (int j = 0; j < deb_of(m); j++)
                        if (rh[SYNC-1+j][c] == m_lvl[m][c]) flip = 1'b0;
                    newl[c] = flip ? ~m_lvl[m][c] : m_lvl[m][c];
                    if (m_lvl[m][c]) m_held[m][c] = (m_held[m][c] < STUCK) ? m_held[m][c] + 1 : STUCK;
                    else             m_held[m][c] = 0;
`ifdef ELEVATOR_STUCK_DETECT_EN
                    m_stuck[m][c] = m_lvl[m][c] && (m_held[m][c] == STUCK);
`else
                    m_stuck[m][c] = 1'b0;
`endif
                end
                m_press[m] = newl & ~m_lvl[m] & ~mask & ~stk_pre;
                m_lvl[m]   = newl;
            end
            for (int k = 7; k > 0; k--) rh[k] = rh[k-1];
            rh[0] = raw;
        end
    endtask

    task automatic step(input logic [N-1:0] raw, input logic [N-1:0] mask, input logic r);
        bif0.btn_raw = raw;  bif1.btn_raw = raw;
        bif0.btn_mask = mask; bif1.btn_mask = mask;
        rst = r;
        @(posedge clk);
        model_edge(raw, mask, r);
        #1;
        chk("level0", 32'(bif0.btn_level), 32'(m_lvl[0]));
        chk("press0", 32'(bif0.btn_press), 32'(m_press[0]));
        chk("stuck0", 32'(bif0.btn_stuck), 32'(m_stuck[0]));
        chk("level1", 32'(bif1.btn_level), 32'(m_lvl[1]));
        chk("press1", 32'(bif1.btn_press), 32'(m_press[1]));
        chk("stuck1", 32'(bif1.btn_stuck), 32'(m_stuck[1]));
    endtask

`ifdef ELEVATOR_STUCK_DETECT_EN
    localparam int EXP_STUCK_RISE = 6 + STUCK;
    localparam int EXP_STUCK_FALL = 7;
`else
    localparam int EXP_STUCK_RISE = -1;
    localparam int EXP_STUCK_FALL = 1;
`endif

    initial begin
        logic [N-1:0] raw, mask;
        int first0, first1, cnt0, cnt1, lvl_fall;
        raw = '0; mask = '0;
        bif0.btn_raw = '0; bif1.btn_raw = '0;
        bif0.btn_mask = '0; bif1.btn_mask = '0;
        rst = 1'b1;

        step('0, '0, 1'b1);
        step('0, '0, 1'b1);
        chk("reset_level", 32'(bif0.btn_level | bif1.btn_level), 32'd0);
        chk("reset_press", 32'(bif0.btn_press | bif1.btn_press), 32'd0);
        repeat (3) step('0, '0, 1'b0);

        // 1: held press, one pulse at edge 6 (edge 3 for the DEBOUNCE_CYCLES=1 instance)
        raw = '0; raw[BTN_FL1_UP] = 1'b1;
        first0 = -1; first1 = -1; cnt0 = 0; cnt1 = 0;
        for (int s = 1; s <= 20; s++) begin
            step(raw, '0, 1'b0);
            if (bif0.btn_press[BTN_FL1_UP]) begin cnt0++; if (first0 < 0) first0 = s; end
            if (bif1.btn_press[BTN_FL1_UP]) begin cnt1++; if (first1 < 0) first1 = s; end
        end
        chk("t1_press_edge0", first0, 6);
        chk("t1_press_edge1", first1, 3);
        chk("t1_pulses0", cnt0, 1);
        chk("t1_pulses1", cnt1, 1);
        chk("t1_level", 32'(bif0.btn_level[BTN_FL1_UP]), 32'd1);
        repeat (10) step('0, '0, 1'b0);
        chk("t1_release", 32'(bif0.btn_level[BTN_FL1_UP]), 32'd0);

        // 2: 3-cycle glitch rejected by DEBOUNCE_CYCLES=4, passed by DEBOUNCE_CYCLES=1
        raw = '0; raw[BTN_CAB2] = 1'b1;
        cnt0 = 0; cnt1 = 0;
        for (int s = 0; s < 11; s++) begin
            step((s < 3) ? raw : '0, '0, 1'b0);
            if (bif0.btn_press[BTN_CAB2] || bif0.btn_level[BTN_CAB2]) cnt0++;
            if (bif1.btn_press[BTN_CAB2]) cnt1++;
        end
        chk("t2_glitch0", cnt0, 0);
        chk("t2_glitch1_pulses", cnt1, 1);

        // 3: simultaneous presses
        raw = '0; raw[BTN_FL2_UP] = 1'b1; raw[BTN_CAB3] = 1'b1;
        first0 = -1;
        for (int s = 1; s <= 8; s++) begin
            step(raw, '0, 1'b0);
            if (bif0.btn_press[BTN_FL2_UP] && bif0.btn_press[BTN_CAB3]) first0 = s;
        end
        chk("t3_same_cycle", first0, 6);
        repeat (8) step('0, '0, 1'b0);

        // 4: masked channel debounces but never pulses
        raw = '0; raw[BTN_FL2_DN] = 1'b1;
        mask = '0; mask[BTN_FL2_DN] = 1'b1;
        cnt0 = 0;
        for (int s = 1; s <= 8; s++) begin
            step(raw, mask, 1'b0);
            if (bif0.btn_press[BTN_FL2_DN]) cnt0++;
            if (s == 6) chk("t4_level_at6", 32'(bif0.btn_level[BTN_FL2_DN]), 32'd1);
        end
        chk("t4_no_pulse", cnt0, 0);
        repeat (8) step('0, mask, 1'b0);
        mask = '0;

        // 5: reset mid-debounce, fresh pulse 6 edges after reset releases
        raw = '0; raw[BTN_FL3_DN] = 1'b1;
        repeat (3) step(raw, '0, 1'b0);
        step(raw, '0, 1'b1);
        chk("t5_in_reset", 32'({bif0.btn_level, bif0.btn_press, bif0.btn_stuck}), 32'd0);
        first0 = -1;
        for (int s = 1; s <= 10; s++) begin
            step(raw, '0, 1'b0);
            if (bif0.btn_press[BTN_FL3_DN] && first0 < 0) first0 = s;
        end
        chk("t5_press_after_rst", first0, 6);
        repeat (8) step('0, '0, 1'b0);

        // 6: long hold for stuck detection, then release
        raw = '0; raw[BTN_CAB1] = 1'b1;
        first0 = -1;
        for (int s = 1; s <= 30; s++) begin
            step(raw, '0, 1'b0);
            if (bif0.btn_stuck[BTN_CAB1] && first0 < 0) first0 = s;
        end
        chk("t6_stuck_rise", first0, EXP_STUCK_RISE);
        first0 = -1; lvl_fall = -1;
        for (int s = 1; s <= 10; s++) begin
            step('0, '0, 1'b0);
            if (!bif0.btn_level[BTN_CAB1] && lvl_fall < 0) lvl_fall = s;
            if (!bif0.btn_stuck[BTN_CAB1] && first0 < 0) first0 = s;
        end
        chk("t6_level_fall", lvl_fall, 6);
        chk("t6_stuck_fall", first0, EXP_STUCK_FALL);

        // random phase
        raw = '0; mask = '0;
        for (int s = 0; s < 3000; s++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 11) == 0) raw[c] = ~raw[c];
                if ($urandom_range(0, 49) == 0) mask[c] = ~mask[c];
            end
            step(raw, mask, ($urandom_range(0, 399) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
